fft_ctrl: RTL and testbench
===========================

# fft_ctrl

Sequencing controller for the 32-point radix-2 single-path delay-feedback (SDF) FFT pipeline. It accepts streamed input samples and generates the global pipeline advance enable. It drives per-stage butterfly/pass mode selects and per-stage twiddle exponents, then issues `start_sorting` and frame-done strobes to the bit-reversal sorting buffer. A final flush drains the last frame after the input stream ends.

## Interface
- `NPT`, 32: points per frame; only 32 is supported and the value is fixed by the package constant.
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: input sample present this cycle.
- `in_last` input 1: qualifies an accepted sample as the final sample of the stream.
- `in_ready` output 1: controller accepts a sample this cycle.
- `pipe_en` output 1: advance all stage delay lines and the sorter by one sample.
- `bf_sel` output 5: bit k = 1 puts stage k in butterfly mode, 0 in pass/fill mode.
- `tw_exp` output 16: packed 4-bit W32 exponents for stages 0..3, with stage k at bits [4k+3:4k]. Stage 4 always uses exponent 0.
- `start_sorting` output 1: first sample of a frame reaches the sorter this cycle.
- `frame_done` output 1: registered pulse, sorter holds a complete reordered frame.
- `err` output 1: registered pulse on a misaligned `in_last`.
- `busy` output 1: state is not IDLE.

## Operation
- Registers:
  - `g[4:0]`: global advance counter, wraps at 32.
  - `fill[4:0]`: advances since leaving IDLE, saturates at 31.
  - `fcnt[4:0]`: flush counter.
  - `state`: one of IDLE, RUN, FLUSH.
- Advance rule: `pipe_en` = (`in_valid` & `in_ready`) | (state == FLUSH). `g` and `fill` update only when `pipe_en` is high.
- `in_ready` = 1 in IDLE and RUN, 0 in FLUSH.
- Stage parameters for stages k = 0..4:
  - delay D_k = 16, 8, 4, 2, 1.
  - offset L_k = 0, 16, 24, 28, 30.
  - local count c_k = (g − L_k) mod 32.
- Stage k is active when `fill` ≥ L_k.
- `bf_sel[k]` = active_k & c_k[4−k].
- `tw_exp` stage k = (c_k mod D_k) << k when active_k and `bf_sel[k]` = 0; otherwise 0. Widths are truncated to 4 bits.
- `bf_sel` and `tw_exp` are combinational from the registered `g` and `fill`, and describe the sample advancing in the current cycle.
- `start_sorting` = `pipe_en` & (`g` == 31) & (`fill` == 31). It is combinational and aligned with the advance.
- `frame_done` is set in the cycle after an advance with (`g` == 30) & (`fill` == 31).
- State transitions:
  - IDLE → RUN on the first accepted sample.
  - RUN → FLUSH on an accepted sample with `in_last` = 1 and `g` == 31. `fcnt` clears on this transition.
  - An accepted `in_last` with `g` ≠ 31 is ignored for sequencing, pulses `err`, and the state stays RUN.
  - FLUSH advances every cycle. After 31 flush advances (`fcnt` == 30 at the advance), the next state is IDLE with `g`, `fill` and `fcnt` cleared.
- Gaps: in RUN with `in_valid` = 0, `pipe_en` = 0 and all counters hold. Frames stream back-to-back with no bubbles required.
- Latency: a sample accepted at advance n reaches the sorter at advance n+31.

## Timing
- Reset values: `in_ready`=1, `pipe_en`=0, `bf_sel`=0, `tw_exp`=0, `start_sorting`=0, `frame_done`=0, `err`=0, `busy`=0; `g`=`fill`=`fcnt`=0; state IDLE.
- Reset asserted mid-RUN or mid-FLUSH aborts immediately and returns all registers to their reset values. No partial frame is reported.
- Frame f (0-based):
  - input occupies advances 32f..32f+31.
  - `start_sorting` is at advance 32f+31.
  - `frame_done` is one cycle after advance 32f+62.
- The last frame's `frame_done` coincides with the first IDLE cycle after FLUSH.
- `start_sorting` can never fire in FLUSH, because `g` spans 0..30 there.

## Structure
- Shared package `fft_pkg` holds:
  - NPT=32, LOG2N=5.
  - stage delay array D and offset array L.
  - sort latency 31.
  - twiddle exponent width 4.
  - state enum {IDLE, RUN, FLUSH}.
- Sub-module `fft_stage_seq`: purely combinational mapping (`g`, `fill`) → (`bf_sel`, `tw_exp`). It is reused by the verification model.

## Test plan
- Single frame of 32 back-to-back samples with `in_last` on sample 31:
  - `start_sorting` at cycle 31 (advance 31).
  - `in_ready`=0 for 31 cycles.
  - `frame_done` at cycle 63, then `busy`=0.
- Mode and twiddle check, advance-by-advance against the formula:
  - `bf_sel[0]` = 0 on advances 0–15 and 1 on advances 16–31.
  - stage-1 `tw_exp` = 0, 2, 4…14 on advances 16–23.
  - `bf_sel[4]` first goes high at advance 31.
- Random `in_valid` gaps over 3 frames: `start_sorting` occurs exactly at accepted-sample counts 31, 63, 95, and `frame_done` occurs exactly 3 times.
- `in_last` on sample 17: `err` pulses once, state stays RUN, and a subsequent `in_last` at `g`=31 flushes normally.
- `rst` low during FLUSH at `fcnt`=10: all outputs return to reset values, no `frame_done`, and a new stream restarts with `g`=0.
- Two streams separated by IDLE cycles: the second stream's `start_sorting` occurs 31 advances after its first sample.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and types for the 32-point radix-2 SDF FFT sequencing logic.
package fft_pkg;

   localparam int NPT      = 32;
   localparam int LOG2N    = 5;
   localparam int NSTG     = LOG2N;
   localparam int SORT_LAT = NPT - 1;
   localparam int TW_W     = 4;
   localparam int TW_BUS_W = (NSTG - 1) * TW_W;

   // Per-stage delay-line length D_k and advance offset L_k, element k at index k.
   localparam logic [NSTG-1:0][LOG2N-1:0] STG_D = {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};
   localparam logic [NSTG-1:0][LOG2N-1:0] STG_L = {5'd30, 5'd28, 5'd24, 5'd16, 5'd0};

   // Counter values that matter to the sequencer.
   localparam logic [LOG2N-1:0] CNT_LAST   = LOG2N'(NPT - 1);
   localparam logic [LOG2N-1:0] CNT_FD     = LOG2N'(NPT - 2);
   localparam logic [LOG2N-1:0] FLUSH_LAST = LOG2N'(SORT_LAT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/fft_stage_seq.sv
// Combinational map from the global advance counter and fill level to the
// per-stage butterfly/pass selects and twiddle exponents.
module fft_stage_seq
   import fft_pkg::*;
(
   input  logic [LOG2N-1:0]    g,
   input  logic [LOG2N-1:0]    fill,
   output logic [NSTG-1:0]     bf_sel,
   output logic [TW_BUS_W-1:0] tw_exp
);

   // Butterfly mode when the stage is primed and its local count is in the upper half-period.
   always_comb begin : p_bf
      logic [LOG2N-1:0] c;
      c      = '0;
      bf_sel = '0;
      for (int k = 0; k < NSTG; k++) begin
         c         = g - STG_L[k];
         bf_sel[k] = (fill >= STG_L[k]) & c[LOG2N-1-k];
      end
   end

   // Twiddle exponent applies during the pass half; stage 4 is trivially W^0 and not carried.
   always_comb begin : p_tw
      logic [LOG2N-1:0] c;
      c      = '0;
      tw_exp = '0;
      for (int k = 0; k < NSTG - 1; k++) begin
         c = g - STG_L[k];
         if ((fill >= STG_L[k]) && !c[LOG2N-1-k])
            tw_exp[TW_W*k +: TW_W] = TW_W'((c & (STG_D[k] - 1'b1)) << k);
      end
   end

endmodule

// File: rtl/fft_ctrl.sv
// Sequencing controller for the 32-point SDF FFT: accepts the sample stream,
// generates the pipeline advance, stage modes/twiddles, sorter strobes and
// drains the final frame with a flush.
module fft_ctrl
   import fft_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_last,
   output logic                in_ready,
   output logic                pipe_en,
   output logic [NSTG-1:0]     bf_sel,
   output logic [TW_BUS_W-1:0] tw_exp,
   output logic                start_sorting,
   output logic                frame_done,
   output logic                err,
   output logic                busy
);

   state_t           state;
   logic [LOG2N-1:0] g;
   logic [LOG2N-1:0] fill;
   logic [LOG2N-1:0] fcnt;
   logic             accept;
   logic             last_ok;

   assign in_ready      = (state != FLUSH);
   assign accept        = in_valid & in_ready;
   assign pipe_en       = accept | (state == FLUSH);
   assign busy          = (state != IDLE);
   assign last_ok       = (g == CNT_LAST);
   assign start_sorting = pipe_en & last_ok & (fill == CNT_LAST);

   fft_stage_seq u_stage_seq (
      .g      (g),
      .fill   (fill),
      .bf_sel (bf_sel),
      .tw_exp (tw_exp)
   );

   // Sequencer state, advance counters and registered sorter/error pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         g          <= '0;
         fill       <= '0;
         fcnt       <= '0;
         frame_done <= 1'b0;
         err        <= 1'b0;
      end else begin
         frame_done <= pipe_en & (g == CNT_FD) & (fill == CNT_LAST);
         err        <= accept & in_last & ~last_ok;

         if (pipe_en) begin
            g <= g + 1'b1;
            if (fill != CNT_LAST)
               fill <= fill + 1'b1;
         end

         case (state)
            IDLE: begin
               if (accept)
                  state <= RUN;
            end
            RUN: begin
               // A misaligned in_last only raises err; the stream keeps running.
               if (accept && in_last && last_ok) begin
                  state <= FLUSH;
                  fcnt  <= '0;
               end
            end
            FLUSH: begin
               if (fcnt == FLUSH_LAST) begin
                  state <= IDLE;
                  g     <= '0;
                  fill  <= '0;
                  fcnt  <= '0;
               end else begin
                  fcnt <= fcnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: cycle model plus start_sorting/frame_done scoreboard.
module tb_fft_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic        pipe_en;
   logic [4:0]  bf_sel;
   logic [15:0] tw_exp;
   logic        start_sorting;
   logic        frame_done;
   logic        err;
   logic        busy;

   fft_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .pipe_en       (pipe_en),
      .bf_sel        (bf_sel),
      .tw_exp        (tw_exp),
      .start_sorting (start_sorting),
      .frame_done    (frame_done),
      .err           (err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_FLUSH = 2;

   int n_chk  = 0;
   int n_fail = 0;

   // reference model state
   int   m_st, m_g, m_fill, m_fcnt;
   logic m_fd, m_err;
   int   adv, last_adv, s_adv, ss_adv_seen;
   int   ss_q[$];
   int   fd_q[$];
   int   n_fd_seen = 0, n_ss_seen = 0, n_err_seen = 0;

   typedef struct {
      int          adv;
      logic [4:0]  bf;
      logic [15:0] tw;
      logic        ss;
      logic        rdy;
   } vec_t;
   localparam int NTBL = 14;
   vec_t tbl[NTBL];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [4:0] exp_bf(input int g, input int f);
      int L[5] = '{0, 16, 24, 28, 30};
      logic [4:0] r = '0;
      for (int k = 0; k < 5; k++) begin
         int c = (g - L[k] + 32) % 32;
         if (f >= L[k]) r[k] = ((c >> (4 - k)) & 1) != 0;
      end
      return r;
   endfunction

   function automatic logic [15:0] exp_tw(input int g, input int f);
      int L[5] = '{0, 16, 24, 28, 30};
      logic [15:0] r = '0;
      for (int k = 0; k < 4; k++) begin
         int c = (g - L[k] + 32) % 32;
         int d = 16 >> k;
         if (f >= L[k] && ((c >> (4 - k)) & 1) == 0)
            r[4*k +: 4] = 4'(((c % d) << k) & 15);
      end
      return r;
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_g = 0; m_fill = 0; m_fcnt = 0;
      m_fd = 1'b0; m_err = 1'b0;
      adv = 0; last_adv = -1; s_adv = 0;
      ss_q.delete();
      fd_q.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"},      in_ready,      1);
      check({tag, "_pipe_en"},       pipe_en,       0);
      check({tag, "_bf_sel"},        bf_sel,        0);
      check({tag, "_tw_exp"},        tw_exp,        0);
      check({tag, "_start_sorting"}, start_sorting, 0);
      check({tag, "_frame_done"},    frame_done,    0);
      check({tag, "_err"},           err,           0);
      check({tag, "_busy"},          busy,          0);
   endtask

   // One clock cycle: drive at negedge, compare 1 ns later, then advance the model.
   task automatic step(input logic v, input logic l);
      logic acc, e_pe, clr;
      int   nxt, tmp;
      @(negedge clk);
      in_valid = v;
      in_last  = l;
      #1;
      acc   = v && (m_st != M_FLUSH);
      e_pe  = acc || (m_st == M_FLUSH);
      s_adv = adv;
      check("in_ready",   in_ready,   m_st != M_FLUSH);
      check("pipe_en",    pipe_en,    e_pe);
      check("busy",       busy,       m_st != M_IDLE);
      check("bf_sel",     bf_sel,     exp_bf(m_g, m_fill));
      check("tw_exp",     tw_exp,     exp_tw(m_g, m_fill));
      check("frame_done", frame_done, m_fd);
      check("err",        err,        m_err);
      if (err) n_err_seen++;
      if (frame_done) begin
         n_fd_seen++;
         if (fd_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL fd_unexpected: frame_done=1, required 0 (t=%0t)", $time);
         end else begin
            tmp = fd_q.pop_front();
            check("fd_adv", last_adv, tmp);
         end
      end
      if (start_sorting) begin
         n_ss_seen++;
         ss_adv_seen = s_adv;
         if (ss_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL ss_unexpected: start_sorting=1, required 0 (t=%0t)", $time);
         end else begin
            tmp = ss_q.pop_front();
            check("ss_adv", s_adv, tmp);
         end
      end
      if (acc && m_g == 0) begin
         ss_q.push_back(adv + 31);
         fd_q.push_back(adv + 62);
      end
      // model update for the coming edge
      m_fd     = e_pe && m_g == 30 && m_fill == 31;
      m_err    = acc && l && (m_g != 31);
      last_adv = e_pe ? adv : -1;
      nxt = m_st;
      clr = 1'b0;
      case (m_st)
         M_IDLE:  if (acc) nxt = M_RUN;
         M_RUN:   if (acc && l && m_g == 31) begin nxt = M_FLUSH; m_fcnt = 0; end
         default: if (m_fcnt == 30) begin nxt = M_IDLE; clr = 1'b1; end else m_fcnt++;
      endcase
      if (e_pe) begin
         m_g = (m_g + 1) % 32;
         if (m_fill < 31) m_fill++;
         adv++;
      end
      if (clr) begin m_g = 0; m_fill = 0; m_fcnt = 0; adv = 0; end
      m_st = nxt;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nrdy0, fd_cyc, fd0, ss0, e0, acc_cnt;
      logic busy_at_fd, v;

      tbl[0]  = '{0,  5'b00000, 16'h0000, 1'b0, 1'b1};
      tbl[1]  = '{5,  5'b00000, 16'h0005, 1'b0, 1'b1};
      tbl[2]  = '{15, 5'b00000, 16'h000F, 1'b0, 1'b1};
      tbl[3]  = '{16, 5'b00001, 16'h0000, 1'b0, 1'b1};
      tbl[4]  = '{19, 5'b00001, 16'h0060, 1'b0, 1'b1};
      tbl[5]  = '{23, 5'b00001, 16'h00E0, 1'b0, 1'b1};
      tbl[6]  = '{24, 5'b00011, 16'h0000, 1'b0, 1'b1};
      tbl[7]  = '{26, 5'b00011, 16'h0800, 1'b0, 1'b1};
      tbl[8]  = '{28, 5'b00111, 16'h0000, 1'b0, 1'b1};
      tbl[9]  = '{29, 5'b00111, 16'h8000, 1'b0, 1'b1};
      tbl[10] = '{30, 5'b01111, 16'h0000, 1'b0, 1'b1};
      tbl[11] = '{31, 5'b11111, 16'h0000, 1'b1, 1'b1};
      tbl[12] = '{33, 5'b10000, 16'h8421, 1'b0, 1'b0};
      tbl[13] = '{62, 5'b01111, 16'h0000, 1'b0, 1'b0};

      // reset
      rst = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      model_reset();
      #1;
      check_reset_vals("por");
      repeat (3) @(negedge clk);
      rst = 1'b1;

      // single back-to-back frame with table checkpoints
      nrdy0 = 0; fd_cyc = -1; busy_at_fd = 1'bx;
      for (int i = 0; i < 66; i++) begin
         step(i < 32, i == 31);
         for (int t = 0; t < NTBL; t++)
            if (tbl[t].adv == i) begin
               check($sformatf("tbl%0d_bf", i),  bf_sel,        tbl[t].bf);
               check($sformatf("tbl%0d_tw", i),  tw_exp,        tbl[t].tw);
               check($sformatf("tbl%0d_ss", i),  start_sorting, tbl[t].ss);
               check($sformatf("tbl%0d_rdy", i), in_ready,      tbl[t].rdy);
            end
         if (!in_ready) nrdy0++;
         if (frame_done) begin fd_cyc = i; busy_at_fd = busy; end
      end
      check("sf_notready_cycles", nrdy0, 31);
      check("sf_fd_cycle", fd_cyc, 63);
      check("sf_busy_at_fd", busy_at_fd, 0);

      // three frames with random input gaps
      fd0 = n_fd_seen; ss0 = n_ss_seen; acc_cnt = 0;
      for (int cyc = 0; cyc < 2000 && acc_cnt < 96; cyc++) begin
         v = ($urandom_range(0, 3) != 0);
         step(v, v && acc_cnt == 95);
         if (v) acc_cnt++;
      end
      check("rand_accepted", acc_cnt, 96);
      repeat (40) step(1'b0, 1'b0);
      check("rand_fd_count", n_fd_seen - fd0, 3);
      check("rand_ss_count", n_ss_seen - ss0, 3);

      // misaligned in_last on sample 17, aligned one on sample 63
      e0 = n_err_seen; fd0 = n_fd_seen;
      for (int i = 0; i < 64; i++) begin
         step(1'b1, i == 17 || i == 63);
         if (i == 19) check("err_still_running", busy && in_ready, 1);
      end
      repeat (40) step(1'b0, 1'b0);
      check("err_count", n_err_seen - e0, 1);
      check("err_fd_count", n_fd_seen - fd0, 2);

      // reset in the middle of a flush
      fd0 = n_fd_seen;
      for (int i = 0; i < 32; i++) step(1'b1, i == 31);
      for (int i = 0; i < 40 && !(m_st == M_FLUSH && m_fcnt == 10); i++) step(1'b0, 1'b0);
      check("flush_reached_fcnt10", m_fcnt, 10);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      #2 rst = 1'b0;
      #1 check_reset_vals("rst_flush");
      repeat (2) @(negedge clk);
      #1 check_reset_vals("rst_hold");
      rst = 1'b1;
      model_reset();
      repeat (40) step(1'b0, 1'b0);
      check("rst_no_fd", n_fd_seen - fd0, 0);
      for (int i = 0; i < 32; i++) step(1'b1, i == 31);
      check("restart_ss_adv", ss_adv_seen, 31);
      repeat (40) step(1'b0, 1'b0);
      check("restart_fd_count", n_fd_seen - fd0, 1);

      // two streams separated by idle cycles, second one with a gap
      for (int i = 0; i < 32; i++) step(1'b1, i == 31);
      repeat (45) step(1'b0, 1'b0);
      ss_adv_seen = -1;
      acc_cnt = 0;
      for (int i = 0; i < 40 && acc_cnt < 32; i++) begin
         v = !(i == 3 || i == 4 || i == 20);
         step(v, v && acc_cnt == 31);
         if (v) acc_cnt++;
      end
      check("second_ss_adv", ss_adv_seen, 31);
      repeat (40) step(1'b0, 1'b0);

      check("ss_q_empty", ss_q.size(), 0);
      check("fd_q_empty", fd_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
